keypad_scan_engine: RTL

KEYPAD_SCAN_ENGINE -- requirements
Module: keypad_scan_engine

---
 rtl/keypad_pkg.sv | 27 ++
 rtl/keypad_event_fifo.sv | 54 +++++
 rtl/keypad_scan_engine.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types for the keypad scan engine: debounce FSM states and the
// per-scan classification of how many keys were seen.
package keypad_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_PRESSED  = 2'd2,
      ST_RELEASE  = 2'd3
   } kp_state_e;

   typedef enum logic [1:0] {
      SCAN_NONE   = 2'd0,
      SCAN_SINGLE = 2'd1,
      SCAN_MULTI  = 2'd2
   } kp_scan_e;

   // Map a saturated key count (0, 1, 2 meaning "two or more") to a class.
   function automatic kp_scan_e classify_scan(input logic [1:0] n_keys);
      case (n_keys)
         2'd0:    classify_scan = SCAN_NONE;
         2'd1:    classify_scan = SCAN_SINGLE;
         default: classify_scan = SCAN_MULTI;
      endcase
   endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// Small key-event FIFO. A push while full (with no simultaneous pop) is
// dropped and reported by a one-cycle overflow pulse; a push together with
// a pop while full succeeds. Head data reads as zero when empty.
module keypad_event_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_empty,
   output logic             o_full,
   output logic             o_overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             r_overflow;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty    = (r_wr_ptr == r_rd_ptr);
   assign o_full     = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                       (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign w_do_pop   = i_pop && !o_empty;
   assign w_do_push  = i_push && (!o_full || w_do_pop);
   assign o_data     = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
   assign o_overflow = r_overflow;

   // Pointer bookkeeping and the dropped-event pulse.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_overflow <= i_push && o_full && !w_do_pop;
      end
   end

   // Storage array; contents are meaningless until written, so no reset.
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/keypad_scan_engine.sv
// Matrix keypad scanner: drives one row low at a time, samples the
// synchronised columns at the end of each row dwell, classifies every full
// scan and debounces single-key presses into events queued in a FIFO.
// Optional build macro KEYPAD_REPEAT_EN adds auto-repeat while a key is held.
module keypad_scan_engine
   import keypad_pkg::*;
#(
   parameter int N_ROWS         = 4,
   parameter int N_COLS         = 4,
   parameter int SCAN_DIV       = 3000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int FIFO_DEPTH     = 4,
   parameter int REPEAT_DELAY   = 100,
   parameter int REPEAT_RATE    = 25,
   localparam int KW            = $clog2(N_ROWS*N_COLS)
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [N_ROWS-1:0] rows,
   input  logic [N_COLS-1:0] cols,
   output logic              key_valid,
   output logic [KW-1:0]     key_code,
   input  logic              key_ready,
   output logic              key_held,
   output logic              overflow
);

   localparam int ROW_W = $clog2(N_ROWS);
   localparam int COL_W = $clog2(N_COLS);
   localparam int DIV_W = $clog2(SCAN_DIV+1);
   localparam int CNT_W = $clog2(DEBOUNCE_SCANS+1);

   logic [N_COLS-1:0] r_cols_s1;
   logic [N_COLS-1:0] r_cols_s2;
   logic [DIV_W-1:0]  r_div;
   logic [ROW_W-1:0]  r_row;
   logic [1:0]        r_acc_n;
   logic [KW-1:0]     r_acc_code;
   kp_state_e         r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [KW-1:0]     r_cand;
   logic              r_held;

   logic              w_dwell_end;
   logic              w_scan_end;
   logic [1:0]        w_row_n;
   logic [COL_W-1:0]  w_row_col;
   logic [KW-1:0]     w_row_code;
   logic [2:0]        w_sum;
   logic [1:0]        w_tot_n;
   logic [KW-1:0]     w_tot_code;
   kp_scan_e          w_class;
   kp_state_e         w_state_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [KW-1:0]     w_cand_nxt;
   logic              w_held_nxt;
   logic              w_push;
   logic              w_enter_press;
   logic              w_resume;
   logic              w_rep_push;
   logic              w_fifo_empty;
   logic              w_fifo_full;
   logic              w_pop;

   assign w_dwell_end = (r_div == DIV_W'(SCAN_DIV-1));
   assign w_scan_end  = w_dwell_end && (r_row == ROW_W'(N_ROWS-1));
   assign rows        = ~(N_ROWS'(1) << r_row);
   assign key_held    = r_held;
   assign key_valid   = !w_fifo_empty;
   assign w_pop       = key_valid && key_ready;

   // Count pressed columns on the active row (saturating at two).
   always_comb begin
      w_row_n   = 2'd0;
      w_row_col = '0;
      for (int c = 0; c < N_COLS; c++) begin
         if (!r_cols_s2[c]) begin
            if (w_row_n != 2'd2) w_row_n = w_row_n + 2'd1;
            w_row_col = COL_W'(c);
         end
      end
   end

   assign w_row_code = KW'(r_row) * KW'(N_COLS) + KW'(w_row_col);
   assign w_sum      = {1'b0, r_acc_n} + {1'b0, w_row_n};
   assign w_tot_n    = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
   assign w_tot_code = (r_acc_n != 2'd0) ? r_acc_code : w_row_code;
   assign w_class    = classify_scan(w_tot_n);

   // Column synchroniser, row dwell timer and per-scan key accumulation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cols_s1  <= '0;
         r_cols_s2  <= '0;
         r_div      <= '0;
         r_row      <= '0;
         r_acc_n    <= 2'd0;
         r_acc_code <= '0;
      end else begin
         r_cols_s1 <= cols;
         r_cols_s2 <= r_cols_s1;
         if (w_dwell_end) begin
            r_div <= '0;
            r_row <= w_scan_end ? '0 : r_row + 1'b1;
            if (w_scan_end) begin
               r_acc_n    <= 2'd0;
               r_acc_code <= '0;
            end else begin
               r_acc_n    <= w_tot_n;
               r_acc_code <= w_tot_code;
            end
         end else begin
            r_div <= r_div + 1'b1;
         end
      end
   end

   // Debounce FSM next state, evaluated only when a full scan completes.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_cand_nxt    = r_cand;
      w_held_nxt    = r_held;
      w_push        = 1'b0;
      w_enter_press = 1'b0;
      w_resume      = 1'b0;
      if (w_scan_end) begin
         case (r_state)
            ST_IDLE: begin
               if (w_class == SCAN_SINGLE) begin
                  w_cand_nxt = w_tot_code;
                  w_cnt_nxt  = CNT_W'(1);
                  if (DEBOUNCE_SCANS == 1) begin
                     w_push        = 1'b1;
                     w_held_nxt    = 1'b1;
                     w_enter_press = 1'b1;
                     w_state_nxt   = ST_PRESSED;
                  end else begin
                     w_state_nxt = ST_DEBOUNCE;
                  end
               end
            end
            ST_DEBOUNCE: begin
               if ((w_class == SCAN_SINGLE) && (w_tot_code == r_cand)) begin
                  w_cnt_nxt = r_cnt + 1'b1;
                  if (w_cnt_nxt == CNT_W'(DEBOUNCE_SCANS)) begin
                     w_push        = 1'b1;
                     w_held_nxt    = 1'b1;
                     w_enter_press = 1'b1;
                     w_state_nxt   = ST_PRESSED;
                  end
               end else begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_PRESSED: begin
               if (w_class == SCAN_NONE) begin
                  w_cnt_nxt = CNT_W'(1);
                  if (DEBOUNCE_SCANS == 1) begin
                     w_held_nxt  = 1'b0;
                     w_cnt_nxt   = '0;
                     w_state_nxt = ST_IDLE;
                  end else begin
                     w_state_nxt = ST_RELEASE;
                  end
               end
            end
            default: begin
               if (w_class == SCAN_NONE) begin
                  w_cnt_nxt = r_cnt + 1'b1;
                  if (w_cnt_nxt == CNT_W'(DEBOUNCE_SCANS)) begin
                     w_held_nxt  = 1'b0;
                     w_cnt_nxt   = '0;
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_resume    = 1'b1;
                  w_state_nxt = ST_PRESSED;
               end
            end
         endcase
      end
   end

   // Debounce FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_cand  <= '0;
         r_held  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_cand  <= w_cand_nxt;
         r_held  <= w_held_nxt;
      end
   end

`ifdef KEYPAD_REPEAT_EN
   localparam int REP_W = $clog2(REPEAT_DELAY+REPEAT_RATE+1);

   logic [REP_W-1:0] r_rep;
   logic             r_rep_first;
   logic [REP_W-1:0] w_rep_inc;
   logic             w_rep_tick;

   assign w_rep_inc  = r_rep + 1'b1;
   assign w_rep_tick = w_scan_end && (r_state == ST_PRESSED) && (w_class != SCAN_NONE);
   assign w_rep_push = w_rep_tick &&
                       (r_rep_first ? (w_rep_inc == REP_W'(REPEAT_DELAY))
                                    : (w_rep_inc == REP_W'(REPEAT_RATE)));

   // Auto-repeat timer: first repeat after the delay, then at the rate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rep       <= '0;
         r_rep_first <= 1'b1;
      end else if (w_enter_press || w_resume) begin
         r_rep       <= '0;
         r_rep_first <= 1'b1;
      end else if (w_rep_push) begin
         r_rep       <= '0;
         r_rep_first <= 1'b0;
      end else if (w_rep_tick) begin
         r_rep <= w_rep_inc;
      end
   end
`else
   assign w_rep_push = 1'b0;
`endif

   keypad_event_fifo #(
      .WIDTH (KW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_push     (w_push || w_rep_push),
      .i_data     (r_held ? r_cand : w_cand_nxt),
      .i_pop      (w_pop),
      .o_data     (key_code),
      .o_empty    (w_fifo_empty),
      .o_full     (w_fifo_full),
      .o_overflow (overflow)
   );

endmodule
